// File: rtl/top2tree_pkg.sv
// Shared types and ordering rule for the pipelined top-2 selection tree.
package top2tree_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 17;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef struct packed {
        entry_t best;
        entry_t second;
    } node_t;

    // Strict ordering on score only; equal scores never beat, so the left operand keeps ties.
    function automatic logic beats(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b,
                                   input logic              mode);
        logic r;
        case (mode)
            MODE_MAX: r = (a > b);
            MODE_MIN: r = (a < b);
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/top2_merge_node.sv
// Combinational merge of two (best, second) pairs; the left pair wins every tie.
module top2_merge_node
    import top2tree_pkg::*;
(
    input  node_t a,
    input  node_t b,
    input  logic  mode,
    output node_t y
);

    logic a_wins_s;

    // Pick the overall best, then the runner-up from the two remaining candidates.
    always_comb begin
        a_wins_s = !beats(b.best.data, a.best.data, mode);
        y        = a;
        if (a_wins_s) begin
            y.best   = a.best;
            y.second = beats(b.best.data, a.second.data, mode) ? b.best : a.second;
        end else begin
            y.best   = b.best;
            y.second = beats(b.second.data, a.best.data, mode) ? b.second : a.best;
        end
    end

endmodule

// File: rtl/top2tree_pipe.sv
// Fully pipelined top-2 selection tree with MAX/MIN mode and valid/ready flow control.
module top2tree_pipe
    import top2tree_pkg::*;
#(
    parameter int DATA_WIDTH = top2tree_pkg::DATA_W,
    parameter int TAG_WIDTH  = top2tree_pkg::TAG_W,
    parameter int LOG2_N     = 7
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic                                        in_mode,
    input  logic [(1 << LOG2_N)*(DATA_WIDTH+TAG_WIDTH)-1:0] in_vec,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0]             out_top1,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0]             out_top2,
    output logic [DATA_WIDTH-1:0]                       out_margin,
    output logic                                        out_mode
);

    localparam int N_IN = 1 << LOG2_N;
    localparam int W    = DATA_WIDTH + TAG_WIDTH;

    // All tree nodes in one flat array: stage k occupies [N_IN-(N_IN>>k), N_IN-(N_IN>>(k+1))).
    node_t                 node_s [N_IN-1];
    node_t                 node_r [N_IN-1];
    logic [LOG2_N-1:0]     valid_r;
    logic [LOG2_N-1:0]     mode_r;
    logic [LOG2_N-1:0]     load_s;
    logic [LOG2_N-1:0]     mode_in_s;
    logic [DATA_WIDTH-1:0] margin_s;
    logic [DATA_WIDTH-1:0] margin_r;
    logic                  stall_s;

    assign stall_s  = valid_r[LOG2_N-1] && !out_ready;
    assign in_ready = !stall_s;

    for (genvar k = 0; k < LOG2_N; k++) begin : g_stage
        for (genvar j = 0; j < (N_IN >> (k + 1)); j++) begin : g_node
            localparam int IDX = N_IN - (N_IN >> k) + j;
            node_t a_s;
            node_t b_s;
            if (k == 0) begin : g_leaf
                entry_t l_s;
                entry_t r_s;
                assign l_s = in_vec[(2*j)*W +: W];
                assign r_s = in_vec[(2*j+1)*W +: W];
                // Crossed pairs make the generic merge reduce to winner/loser of two lanes.
                assign a_s = '{best: l_s, second: r_s};
                assign b_s = '{best: r_s, second: l_s};
            end else begin : g_inner
                localparam int CIDX = N_IN - (N_IN >> (k - 1)) + 2*j;
                assign a_s = node_r[CIDX];
                assign b_s = node_r[CIDX+1];
            end
            top2_merge_node u_merge (
                .a    (a_s),
                .b    (b_s),
                .mode (mode_in_s[k]),
                .y    (node_s[IDX])
            );
        end
    end

    // Per-stage load enables and modes, taken from the stage upstream.
    always_comb begin
        load_s       = '0;
        mode_in_s    = '0;
        load_s[0]    = in_valid;
        mode_in_s[0] = in_mode;
        for (int k = 1; k < LOG2_N; k++) begin
            load_s[k]    = valid_r[k-1];
            mode_in_s[k] = mode_r[k-1];
        end
    end

    // Margin of the final merge, signed by mode so it is never negative.
    always_comb begin
        margin_s = '0;
        if (mode_in_s[LOG2_N-1] == MODE_MAX) begin
            margin_s = node_s[N_IN-2].best.data - node_s[N_IN-2].second.data;
        end else begin
            margin_s = node_s[N_IN-2].second.data - node_s[N_IN-2].best.data;
        end
    end

    // Stage registers: the whole tree advances one level per unstalled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r  <= '0;
            mode_r   <= '0;
            margin_r <= '0;
            for (int i = 0; i < N_IN - 1; i++) begin
                node_r[i] <= '0;
            end
        end else if (!stall_s) begin
            for (int k = 0; k < LOG2_N; k++) begin
                valid_r[k] <= load_s[k];
                if (load_s[k]) begin
                    mode_r[k] <= mode_in_s[k];
                    for (int j = N_IN - (N_IN >> k); j < N_IN - (N_IN >> (k + 1)); j++) begin
                        node_r[j] <= node_s[j];
                    end
                end
            end
            if (load_s[LOG2_N-1]) begin
                margin_r <= margin_s;
            end
        end
    end

    assign out_valid  = valid_r[LOG2_N-1];
    assign out_mode   = mode_r[LOG2_N-1];
    assign out_top1   = node_r[N_IN-2].best;
    assign out_top2   = node_r[N_IN-2].second;
    assign out_margin = margin_r;

endmodule

// File: tb/tb_top2tree_pipe.sv
// Directed and streamed checks of top2tree_pipe at 8 lanes against a linear-scan reference.
module tb_top2tree_pipe;

    localparam int LOG2_N = 3;
    localparam int N      = 8;
    localparam int DW     = 16;
    localparam int TW     = 17;
    localparam int W      = DW + TW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [N*W-1:0] in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_top1;
    logic [W-1:0]  out_top2;
    logic [DW-1:0] out_margin;
    logic          out_mode;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] dat [N];
    logic [TW-1:0] tag [N];
    logic [W-1:0]  q_top1 [$];
    logic [W-1:0]  q_top2 [$];
    logic [DW-1:0] q_margin [$];
    logic          q_mode [$];

    always #5 clk = ~clk;

    top2tree_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .LOG2_N(LOG2_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_top1   (out_top1),
        .out_top2   (out_top2),
        .out_margin (out_margin),
        .out_mode   (out_mode)
    );

    function automatic logic [N*W-1:0] pack_vec();
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = {tag[i], dat[i]};
        return v;
    endfunction

    function automatic logic better(input int i, input int j, input logic mode);
        return mode ? (dat[i] < dat[j]) : (dat[i] > dat[j]);
    endfunction

    // Reference: linear scan, strict improvement only, so ties keep the lowest lane.
    task automatic push_golden(input logic mode);
        int b1;
        int b2;
        logic [DW-1:0] m;
        b1 = 0;
        for (int i = 1; i < N; i++) if (better(i, b1, mode)) b1 = i;
        b2 = (b1 == 0) ? 1 : 0;
        for (int i = 0; i < N; i++) if (i != b1 && better(i, b2, mode)) b2 = i;
        m = mode ? (dat[b2] - dat[b1]) : (dat[b1] - dat[b2]);
        q_top1.push_back({tag[b1], dat[b1]});
        q_top2.push_back({tag[b2], dat[b2]});
        q_margin.push_back(m);
        q_mode.push_back(mode);
    endtask

    task automatic rand_vec();
        for (int i = 0; i < N; i++) begin
            dat[i] = DW'($urandom);
            tag[i] = TW'($urandom);
        end
    endtask

    task automatic index_tags();
        for (int i = 0; i < N; i++) tag[i] = TW'(i);
    endtask

    // Drive one vector into an idle pipe and wait (bounded) for its result.
    task automatic send_single(input logic mode, output int lat);
        in_vec   = pack_vec();
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) $display("FAIL send_timeout: no out_valid within %0d cycles", lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_mode = 1'b0; in_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_top1 !== '0) begin errors++; $display("FAIL reset_top1: got %h want 0", out_top1); end
        checks++; if (out_top2 !== '0) begin errors++; $display("FAIL reset_top2: got %h want 0", out_top2); end
        checks++; if (out_margin !== 16'h0000) begin errors++; $display("FAIL reset_margin: got %h want 0", out_margin); end
        checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b want 0", out_mode); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed_max();
        int lat;
        dat = '{16'd5, 16'd90, 16'd12, 16'd90, 16'd3, 16'd7, 16'd88, 16'd1};
        index_tags();
        send_single(1'b0, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL max_latency: got %0d want 3", lat); end
        checks++; if (out_top1 !== {17'd1, 16'd90}) begin errors++; $display("FAIL max_top1: got %h want %h", out_top1, {17'd1, 16'd90}); end
        checks++; if (out_top2 !== {17'd3, 16'd90}) begin errors++; $display("FAIL max_top2: got %h want %h", out_top2, {17'd3, 16'd90}); end
        checks++; if (out_margin !== 16'd0) begin errors++; $display("FAIL max_margin: got %0d want 0", out_margin); end
        checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL max_mode: got %b want 0", out_mode); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed_min();
        int lat;
        dat = '{16'd5, 16'd90, 16'd12, 16'd90, 16'd3, 16'd7, 16'd88, 16'd1};
        index_tags();
        send_single(1'b1, lat);
        checks++; if (out_top1 !== {17'd7, 16'd1}) begin errors++; $display("FAIL min_top1: got %h want %h", out_top1, {17'd7, 16'd1}); end
        checks++; if (out_top2 !== {17'd4, 16'd3}) begin errors++; $display("FAIL min_top2: got %h want %h", out_top2, {17'd4, 16'd3}); end
        checks++; if (out_margin !== 16'd2) begin errors++; $display("FAIL min_margin: got %0d want 2", out_margin); end
        checks++; if (out_mode !== 1'b1) begin errors++; $display("FAIL min_mode: got %b want 1", out_mode); end
        @(posedge clk); #1;
    endtask

    task automatic test_extremes();
        int lat;
        for (int i = 0; i < N; i++) dat[i] = 16'hFFFF;
        index_tags();
        send_single(1'b0, lat);
        checks++; if (out_top1 !== {17'd0, 16'hFFFF}) begin errors++; $display("FAIL allmax_top1: got %h want %h", out_top1, {17'd0, 16'hFFFF}); end
        checks++; if (out_top2 !== {17'd1, 16'hFFFF}) begin errors++; $display("FAIL allmax_top2: got %h want %h", out_top2, {17'd1, 16'hFFFF}); end
        checks++; if (out_margin !== 16'd0) begin errors++; $display("FAIL allmax_margin: got %h want 0", out_margin); end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) dat[i] = 16'h0000;
        dat[5] = 16'hFFFF;
        send_single(1'b0, lat);
        checks++; if (out_top1 !== {17'd5, 16'hFFFF}) begin errors++; $display("FAIL lane5_top1: got %h want %h", out_top1, {17'd5, 16'hFFFF}); end
        checks++; if (out_top2 !== {17'd0, 16'h0000}) begin errors++; $display("FAIL lane5_top2: got %h want %h", out_top2, {17'd0, 16'h0000}); end
        checks++; if (out_margin !== 16'hFFFF) begin errors++; $display("FAIL lane5_margin: got %h want ffff", out_margin); end
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        logic exp_valid;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 26; cyc++) begin
            if (cyc < 20) begin
                rand_vec();
                in_mode  = ((cyc % 2) == 1);
                in_vec   = pack_vec();
                in_valid = 1'b1;
                push_golden(in_mode);
            end else begin
                in_valid = 1'b0;
            end
            exp_valid = (cyc >= 3 && cyc <= 22);
            checks++;
            if (out_valid !== exp_valid) begin
                errors++; $display("FAIL stream_valid cyc%0d: got %b want %b", cyc, out_valid, exp_valid);
            end
            if (out_valid === 1'b1 && q_top1.size() > 0) begin
                checks++;
                if ({out_top1, out_top2, out_margin, out_mode} !== {q_top1[0], q_top2[0], q_margin[0], q_mode[0]}) begin
                    errors++;
                    $display("FAIL stream_result cyc%0d: got %h/%h/%h/%b want %h/%h/%h/%b", cyc,
                             out_top1, out_top2, out_margin, out_mode, q_top1[0], q_top2[0], q_margin[0], q_mode[0]);
                end
                void'(q_top1.pop_front()); void'(q_top2.pop_front());
                void'(q_margin.pop_front()); void'(q_mode.pop_front());
            end
            @(posedge clk); #1;
        end
        checks++; if (q_top1.size() != 0) begin errors++; $display("FAIL stream_leftover: got %0d pending want 0", q_top1.size()); end
        q_top1.delete(); q_top2.delete(); q_margin.delete(); q_mode.delete();
    endtask

    task automatic test_backpressure();
        int sent;
        int recv;
        logic stalled;
        logic [2*W+DW+1:0] hold;
        sent = 0; recv = 0; hold = '0;
        rand_vec();
        for (int cyc = 0; cyc < 40; cyc++) begin
            stalled   = (cyc >= 6 && cyc <= 9);
            out_ready = !stalled;
            in_valid  = (sent < 10);
            in_mode   = ((sent % 2) == 1);
            in_vec    = pack_vec();
            #1;
            if (stalled) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready); end
                if (cyc == 6) begin
                    hold = {out_valid, out_top1, out_top2, out_margin, out_mode};
                end else begin
                    checks++;
                    if ({out_valid, out_top1, out_top2, out_margin, out_mode} !== hold) begin
                        errors++; $display("FAIL bp_hold cyc%0d: got %h want %h", cyc, {out_valid, out_top1, out_top2, out_margin, out_mode}, hold);
                    end
                end
            end
            if (in_valid && in_ready) begin
                push_golden(in_mode);
                sent++;
                rand_vec();
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q_top1.size() == 0) begin
                    errors++; $display("FAIL bp_extra cyc%0d: got unexpected result %h want none", cyc, out_top1);
                end else begin
                    if ({out_top1, out_top2, out_margin, out_mode} !== {q_top1[0], q_top2[0], q_margin[0], q_mode[0]}) begin
                        errors++;
                        $display("FAIL bp_result cyc%0d: got %h/%h/%h/%b want %h/%h/%h/%b", cyc,
                                 out_top1, out_top2, out_margin, out_mode, q_top1[0], q_top2[0], q_margin[0], q_mode[0]);
                    end
                    void'(q_top1.pop_front()); void'(q_top2.pop_front());
                    void'(q_margin.pop_front()); void'(q_mode.pop_front());
                end
                recv++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (sent != 10) begin errors++; $display("FAIL bp_sent: got %0d want 10", sent); end
        checks++; if (recv != 10) begin errors++; $display("FAIL bp_recv: got %0d want 10", recv); end
        q_top1.delete(); q_top2.delete(); q_margin.delete(); q_mode.delete();
    endtask

    task automatic test_reset_midflight();
        logic seen;
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            rand_vec();
            in_vec = pack_vec(); in_mode = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_loaded: got %b want 1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        checks++; if (out_top1 !== '0) begin errors++; $display("FAIL midrst_top1: got %h want 0", out_top1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_stale: got stale output %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed_max();
        test_directed_min();
        test_extremes();
        test_streaming();
        test_backpressure();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
